// File: rtl/jtag_vpi_pkg.sv
// Shared opcodes, FSM state type and pin-drive helper for the JTAG bit-bang sequencer.
package jtag_vpi_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int LEN_W      = 7;
  localparam int RESET_LEN  = 5;

  localparam logic [2:0] OP_RESET     = 3'd0;
  localparam logic [2:0] OP_TMS_SEQ   = 3'd1;
  localparam logic [2:0] OP_SCAN      = 3'd2;
  localparam logic [2:0] OP_SCAN_FLIP = 3'd3;
  localparam logic [2:0] OP_STOP      = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_t;

  // Returns {tms, tdi} for one shifted bit.
  function automatic logic [1:0] drive_bits(input logic [2:0] op, input logic data_bit,
                                            input logic last_bit);
    case (op)
      OP_RESET:     drive_bits = 2'b10;
      OP_TMS_SEQ:   drive_bits = {data_bit, 1'b0};
      OP_SCAN:      drive_bits = {1'b0, data_bit};
      OP_SCAN_FLIP: drive_bits = {last_bit, data_bit};
      default:      drive_bits = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: TCK_HALF clk cycles per phase, with rise/fall strobes marking the edge that toggles tck.
module jtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_HALF - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             tck_reg;
  logic             run_reg;
  logic             wrap;

  assign wrap = run_reg && (cnt_reg == CNT_LAST);
  assign rise = wrap && !tck_reg;
  assign fall = wrap && tck_reg;
  assign tck  = tck_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      tck_reg <= 1'b0;
      run_reg <= 1'b0;
    end else if (start) begin
      cnt_reg <= '0;
      tck_reg <= 1'b0;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      if (wrap) begin
        cnt_reg <= '0;
        tck_reg <= ~tck_reg;
        // Stopping on a fall leaves tck parked low.
        if (fall && stop) run_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/jtag_vpi_master.sv
// JTAG bit-bang sequencer in front of the SoC debug TAP. Optional macro JTAG_VPI_STOP_EN
// makes opcode 4 raise a sticky stop request; otherwise opcode 4 is an empty response.
module jtag_vpi_master
  import jtag_vpi_pkg::*;
#(
  parameter int TCK_HALF = 2,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tms,
  output logic              tck,
  output logic              tdi,
  input  logic              tdo,
  output logic              stop
);

  localparam logic [LEN_W-1:0] MAX_LEN = (DATA_W > 127) ? 7'd127 : LEN_W'(DATA_W);

  state_t            state_reg, state_next;
  logic [2:0]        op_reg;
  logic [LEN_W-1:0]  len_reg, bit_reg, bit_inc, eff_len;
  logic [DATA_W-1:0] shift_reg, shift_nx, mask_reg, rsp_reg;
  logic              tms_reg, tdi_reg;
  logic              accept, go, last_bit, next_last;
  logic              tck_start, tck_stop, tck_rise, tck_fall;
  logic [1:0]        pins_first, pins_next;

  assign cmd_ready = !rst && (state_reg == ST_IDLE) && enable && init_done;
  assign accept    = cmd_valid && cmd_ready;
  assign eff_len   = (cmd_op == OP_RESET) ? LEN_W'(RESET_LEN)
                   : ((cmd_len > MAX_LEN) ? MAX_LEN : cmd_len);
  assign go        = (cmd_op <= OP_SCAN_FLIP) && (eff_len != '0);

  assign last_bit  = (bit_reg == len_reg - LEN_W'(1));
  assign bit_inc   = bit_reg + LEN_W'(1);
  assign next_last = (bit_inc == len_reg - LEN_W'(1));
  assign shift_nx  = shift_reg >> 1;
  assign pins_first = drive_bits(cmd_op, cmd_data[0], eff_len == LEN_W'(1));
  assign pins_next  = drive_bits(op_reg, shift_nx[0], next_last);

  jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
    .clk   (clk),
    .rst   (rst),
    .start (tck_start),
    .stop  (tck_stop),
    .tck   (tck),
    .rise  (tck_rise),
    .fall  (tck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    tck_start  = 1'b0;
    tck_stop   = 1'b0;
    case (state_reg)
      ST_IDLE: if (accept) begin
        tck_start  = go;
        state_next = go ? ST_LOW : ST_DONE;
      end
      ST_LOW:  if (tck_rise) state_next = ST_HIGH;
      ST_HIGH: if (tck_fall) begin
        tck_stop   = last_bit;
        state_next = last_bit ? ST_DONE : ST_LOW;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg    <= '0;
      len_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      mask_reg  <= '0;
      rsp_reg   <= '0;
      tms_reg   <= 1'b0;
      tdi_reg   <= 1'b0;
    end else if (state_reg == ST_IDLE && accept) begin
      op_reg    <= cmd_op;
      len_reg   <= eff_len;
      bit_reg   <= '0;
      shift_reg <= cmd_data;
      mask_reg  <= DATA_W'(1);
      rsp_reg   <= '0;
      if (go) {tms_reg, tdi_reg} <= pins_first;
    end else if (state_reg == ST_LOW && tck_rise) begin
      if (tdo) rsp_reg <= rsp_reg | mask_reg;
    end else if (state_reg == ST_HIGH && tck_fall && !last_bit) begin
      bit_reg   <= bit_inc;
      shift_reg <= shift_nx;
      mask_reg  <= mask_reg << 1;
      {tms_reg, tdi_reg} <= pins_next;
    end
  end

  assign rsp_valid = !rst && (state_reg == ST_DONE);
  assign rsp_data  = rsp_reg;
  assign tms       = tms_reg;
  assign tdi       = tdi_reg;

`ifdef JTAG_VPI_STOP_EN
  logic stop_reg;
  always_ff @(posedge clk) begin
    if (rst)                             stop_reg <= 1'b0;
    else if (accept && cmd_op == OP_STOP) stop_reg <= 1'b1;
  end
  assign stop = stop_reg;
`else
  assign stop = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_vpi_master.sv
// Directed bench for jtag_vpi_master: per-command TCK/TMS/TDI trace and response checks.
module tb_jtag_vpi_master;

  localparam int TCK_HALF = 2;
  localparam int DATA_W   = 64;

  logic              clk = 1'b0;
  logic              rst, enable, init_done, cmd_valid;
  logic              cmd_ready, rsp_valid, tms, tck, tdi, stop;
  logic [2:0]        cmd_op;
  logic [6:0]        cmd_len;
  logic [DATA_W-1:0] cmd_data, rsp_data;
  logic              loop_en, tdo_val;
  wire               tdo_w = loop_en ? tdi : tdo_val;

  int checks = 0;
  int errors = 0;

  int          r_rises, r_cycle, r_viol;
  logic [63:0] r_tms, r_tdi, r_rsp;
  logic        r_after_valid, r_after_ready;

  jtag_vpi_master #(.TCK_HALF(TCK_HALF), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .init_done (init_done),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tms       (tms),
    .tck       (tck),
    .tdi       (tdi),
    .tdo       (tdo_w),
    .stop      (stop)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command from a negedge and trace pins until rsp_valid (bounded).
  task automatic run_cmd(input logic [2:0] op, input logic [6:0] len,
                         input logic [63:0] data, input logic drop_en);
    logic p_tck, p_tms, p_tdi;
    r_rises = 0; r_cycle = -1; r_viol = 0;
    r_tms = '0; r_tdi = '0; r_rsp = '1;
    check_val($sformatf("ready_op%0d", op), 64'(cmd_ready), 64'd1);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (drop_en) enable = 1'b0;
    p_tck = tck; p_tms = tms; p_tdi = tdi;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (tck && (tms !== p_tms || tdi !== p_tdi)) r_viol++;
      if (tck && !p_tck) begin
        if (r_rises < 64) begin
          r_tms[r_rises] = tms;
          r_tdi[r_rises] = tdi;
        end
        r_rises++;
      end
      p_tck = tck; p_tms = tms; p_tdi = tdi;
      if (rsp_valid) begin
        r_cycle = cyc;
        r_rsp   = rsp_data;
        break;
      end
    end
    @(negedge clk);
    r_after_valid = rsp_valid;
    r_after_ready = cmd_ready;
    $display("cmd op=%0d len=%0d data=%h : rsp_cycle=%0d tck_pulses=%0d rsp_data=%h",
             op, len, data, r_cycle, r_rises, r_rsp);
  endtask

  task automatic check_common(input string tag, input int exp_cycle, input int exp_rises);
    check_val({tag, "_rsp_cycle"}, 64'(r_cycle), 64'(exp_cycle));
    check_val({tag, "_tck_pulses"}, 64'(r_rises), 64'(exp_rises));
    check_val({tag, "_pin_change_tck_high"}, 64'(r_viol), 64'd0);
    check_val({tag, "_rsp_pulse_1cyc"}, 64'(r_after_valid), 64'd0);
  endtask

  initial begin
    int bad;
    logic exp_stop;
    rst = 1'b1; enable = 1'b1; init_done = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_len = '0; cmd_data = '0; loop_en = 1'b0; tdo_val = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_pins", {58'd0, tck, tms, tdi, cmd_ready, rsp_valid, stop}, 64'd0);
    check_val("reset_rsp_data", rsp_data, 64'd0);

    // init_done low: command must sit unaccepted
    init_done = 1'b0; rst = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_len = 7'd4;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || tck !== 1'b0) bad++;
    end
    check_val("gate_init_done", 64'(bad), 64'd0);
    cmd_valid = 1'b0; init_done = 1'b1;
    @(negedge clk);
    check_val("ready_after_init", 64'(cmd_ready), 64'd1);

    run_cmd(3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check_common("reset_op", 21, 5);
    check_val("reset_op_tms", r_tms, 64'h1F);
    check_val("reset_op_tdi", r_tdi, 64'h0);
    check_val("reset_op_tms_hold", 64'(tms), 64'd1);

    loop_en = 1'b1;
    run_cmd(3'd2, 7'd8, 64'hA5, 1'b0);
    check_common("scan_a5", 33, 8);
    check_val("scan_a5_rsp", r_rsp, 64'hA5);
    check_val("scan_a5_tdi", r_tdi, 64'hA5);
    check_val("scan_a5_tms", r_tms, 64'h0);
    check_val("scan_a5_tdi_hold", 64'(tdi), 64'd1);

    loop_en = 1'b0; tdo_val = 1'b0;
    run_cmd(3'd3, 7'd4, 64'hF, 1'b0);
    check_common("flip", 17, 4);
    check_val("flip_tms", r_tms, 64'h8);
    check_val("flip_tdi", r_tdi, 64'hF);
    check_val("flip_rsp", r_rsp, 64'h0);

    run_cmd(3'd1, 7'd6, 64'h1F, 1'b0);
    check_common("tms_seq", 25, 6);
    check_val("tms_seq_tms", r_tms, 64'h1F);
    check_val("tms_seq_tdi", r_tdi, 64'h0);

    tdo_val = 1'b1;
    run_cmd(3'd2, 7'd3, 64'h0, 1'b0);
    check_common("tdo_high_l3", 13, 3);
    check_val("tdo_high_l3_rsp", r_rsp, 64'h7);

    loop_en = 1'b1;
    run_cmd(3'd2, 7'd100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check_common("len_clamp", 257, 64);
    check_val("len_clamp_rsp", r_rsp, 64'hFFFF_FFFF_FFFF_FFFF);

    run_cmd(3'd2, 7'd0, 64'hFF, 1'b0);
    check_common("len_zero", 1, 0);
    check_val("len_zero_rsp", r_rsp, 64'h0);

    run_cmd(3'd7, 7'd8, 64'hFF, 1'b0);
    check_common("op7", 1, 0);
    check_val("op7_rsp", r_rsp, 64'h0);

    // enable drops right after accept: command completes, next accept blocked
    run_cmd(3'd2, 7'd2, 64'h2, 1'b1);
    check_common("enable_drop", 9, 2);
    check_val("enable_drop_rsp", r_rsp, 64'h2);
    check_val("enable_drop_ready", 64'(r_after_ready), 64'd0);
    enable = 1'b1;
    @(negedge clk);

`ifdef JTAG_VPI_STOP_EN
    exp_stop = 1'b1;
`else
    exp_stop = 1'b0;
`endif
    run_cmd(3'd4, 7'd8, 64'hFF, 1'b0);
    check_common("op4", 1, 0);
    check_val("op4_rsp", r_rsp, 64'h0);
    check_val("op4_stop", 64'(stop), 64'(exp_stop));

    // reset during bit 3 of a 32-bit scan
    loop_en = 1'b1;
    cmd_op = 3'd2; cmd_len = 7'd32; cmd_data = 64'hFFFF_FFFF; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (15) @(negedge clk);
    check_val("abort_tck_high_bit3", 64'(tck), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_pins", {59'd0, tck, tms, tdi, rsp_valid, stop}, 64'd0);
    check_val("abort_rsp_data", rsp_data, 64'd0);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || tck !== 1'b0) bad++;
    end
    check_val("abort_quiet", 64'(bad), 64'd0);
    $display("abort: rst in bit 3 of 32-bit scan, activity cycles after=%0d", bad);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_vpi_master.md
# jtag_vpi_master

Synthesizable-style JTAG bit-bang sequencer standing in front of the SoC debug TAP in simulation. It accepts host debug commands over a valid/ready command port, shifts TMS/TDI on a generated TCK, captures TDO, and returns the captured bits. It drives the `tms`/`tck`/`tdi` pads of the SoC top level and listens on `tdo`.

## Interface
- `TCK_HALF`, default 2: clk cycles per TCK half-period; minimum 1.
- `DATA_W`, default 64: maximum bits per command.
- `clk`  in  1  system clock; the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  host link enabled.
- `init_done`  in  1  SoC ready; commands are gated until high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  3  opcode: 0 RESET, 1 TMS_SEQ, 2 SCAN_CHAIN, 3 SCAN_CHAIN_FLIP_TMS, 4 STOP.
- `cmd_len`  in  7  bit count.
- `cmd_data`  in  DATA_W  bits to shift, LSB first.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  DATA_W  captured TDO, bit i = bit i shifted.
- `tms`, `tck`, `tdi`  out  1  JTAG pins.
- `tdo`  in  1  JTAG data in.
- `stop`  out  1  simulation-stop request (see Configuration).

## Operation
- Reset values: `tck`=0, `tms`=0, `tdi`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `stop`=0; FSM in IDLE.
- `cmd_ready` = IDLE && `enable` && `init_done`.
- Effective length L = min(`cmd_len`, DATA_W). RESET uses L=5 and ignores `cmd_len`/`cmd_data`.
- RESET: `tms`=1 and `tdi`=0 for all 5 bits.
- TMS_SEQ: `tms` = data[i], `tdi`=0.
- SCAN_CHAIN: `tdi` = data[i], `tms`=0.
- SCAN_CHAIN_FLIP_TMS: same as SCAN_CHAIN, except `tms`=1 on bit L-1.
- TDO is captured for every opcode; bits ≥ L of `rsp_data` read 0.
- L=0, or opcode 5–7: no TCK edges; `rsp_valid` is asserted the cycle after accept with `rsp_data`=0.
- FSM: IDLE → LOW (drive bit i) → HIGH (sample) → LOW for next bit, or → DONE after bit L-1 → IDLE.
- After completion, `tms`/`tdi` hold their last driven values.
- `enable`/`init_done` falling mid-command does not abort the command; it blocks only the next accept.
- `rst` mid-command aborts immediately: outputs return to reset values and no `rsp_valid` is produced.

## Timing
- Accept at cycle 0. Bit 0 is driven on `tms`/`tdi` at cycle 1 with `tck`=0.
- `tck` is low for TCK_HALF cycles, then high for TCK_HALF cycles.
- `tdo` is registered on the clk edge that raises `tck`.
- The next bit is driven on the cycle `tck` falls. TMS/TDI change only while `tck` is low.
- `rsp_valid` pulses for 1 cycle at cycle 1 + 2·TCK_HALF·L, coincident with the final `tck` fall.
- Earliest next accept is the cycle after `rsp_valid`.

## Configuration
- `JTAG_VPI_STOP_EN` defined: opcode 4 completes like L=0 (no TCK edges, `rsp_valid` after 1 cycle) and sets `stop`=1, which stays set until `rst`.
- Not defined: opcode 4 is treated as illegal (empty response) and `stop` is tied to 0.

## Structure
- Package `jtag_vpi_pkg`: opcode constants, FSM state enum, default DATA_W.
- One sub-module, `jtag_tck_gen`: TCK_HALF counter producing `tck`, a rise strobe and a fall strobe, with start/stop control.

## Test plan
- RESET with TCK_HALF=2: exactly 5 TCK pulses, `tms`=1 throughout, `rsp_valid` at cycle 21.
- SCAN_CHAIN with L=8, data=0xA5, `tdo` looped to `tdi`: `rsp_data`=0xA5, `tms`=0 throughout.
- SCAN_CHAIN_FLIP_TMS with L=4, data=0xF, `tdo`=0: `tms`=1 only during bit 3, `rsp_data`=0.
- TMS_SEQ with L=6, data=0b011111: TMS sequence 1,1,1,1,1,0 (LSB first), `tdi`=0.
- Gating and abort: `init_done`=0 keeps `cmd_ready`=0. `rst` during bit 3 of a 32-bit scan yields all-zero outputs and no `rsp_valid`.
- Opcodes 4 and 7: with `JTAG_VPI_STOP_EN`, op 4 sets `stop`=1. Op 7 gives `rsp_data`=0 after 1 cycle with no `tck` activity.
